hamming_serial_encoder: RTL

HAMMING_SERIAL_ENCODER -- requirements
Module: hamming_serial_encoder

---
 rtl/hamming_serial_encoder.sv | 109 ++++++++++
 1 files changed

// File: rtl/hamming_serial_encoder.sv
// Hamming(7,4)+c0 nibble encoder with a one-deep holding register and an LSB-first serial shifter.
// Optional macro OVERALL_PARITY_EN makes c0 the even overall parity of c1..c7 (otherwise c0 = 0).
module hamming_serial_encoder #(
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       ser_en,
  output logic       ser_out,
  output logic       ser_valid,
  output logic       ser_sof,
  output logic       busy,
  output logic       dbg_state,
  output logic [2:0] dbg_bit_cnt
);

  // Handshake: a nibble is taken on a rising edge where in_valid && in_ready.
  // in_ready is low during reset and otherwise mirrors an empty holding register.

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t     state_q;
  logic [2:0] cnt_q;
  logic [7:0] shreg_q;
  logic [7:0] hold_q;
  logic       hold_full_q;
  logic       ser_out_q;
  logic       ser_valid_q;
  logic       ser_sof_q;
  logic       load;
  logic       accept;

  function automatic logic [7:0] encode(input logic [3:0] d);
    logic [7:0] c;
    c    = '0;
    c[1] = d[3];
    c[2] = d[2];
    c[3] = d[1];
    c[4] = d[0];
    c[5] = d[3] ^ d[1] ^ d[0];
    c[6] = d[3] ^ d[2] ^ d[1];
    c[7] = d[2] ^ d[1] ^ d[0];
`ifdef OVERALL_PARITY_EN
    c[0] = ^c[7:1];
`else
    c[0] = 1'b0;
`endif
    return c;
  endfunction

  // Accept and load are mutually exclusive: accept needs an empty holding
  // register, load needs a full one.
  assign accept = in_valid && !hold_full_q;
  assign load   = hold_full_q &&
                  ((state_q == IDLE) || (ser_en && (cnt_q == 3'd7)));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      shreg_q     <= 8'h00;
      hold_q      <= 8'h00;
      hold_full_q <= 1'b0;
      ser_out_q   <= IDLE_LEVEL;
      ser_valid_q <= 1'b0;
      ser_sof_q   <= 1'b0;
    end else begin
      if (accept) begin
        hold_q      <= encode(in_data);
        hold_full_q <= 1'b1;
      end
      if (load) begin
        shreg_q     <= hold_q;
        ser_out_q   <= hold_q[0];
        cnt_q       <= 3'd0;
        hold_full_q <= 1'b0;
        state_q     <= SHIFT;
        ser_valid_q <= 1'b1;
        ser_sof_q   <= 1'b1;
      end else if (state_q == SHIFT && ser_en) begin
        if (cnt_q == 3'd7) begin
          state_q     <= IDLE;
          ser_valid_q <= 1'b0;
          ser_sof_q   <= 1'b0;
          ser_out_q   <= IDLE_LEVEL;
        end else begin
          cnt_q     <= cnt_q + 3'd1;
          ser_out_q <= shreg_q[cnt_q + 3'd1];
          ser_sof_q <= 1'b0;
        end
      end
    end
  end

  assign in_ready    = !hold_full_q && !reset;
  assign ser_out     = ser_out_q;
  assign ser_valid   = ser_valid_q;
  assign ser_sof     = ser_sof_q;
  assign busy        = (state_q == SHIFT) || hold_full_q;
  assign dbg_state   = state_q;
  assign dbg_bit_cnt = cnt_q;

endmodule
